// File: rtl/reg_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : reg_writeback
//  Purpose  : Write-side controller for the 32x32 register file. Merges
//             single-cycle ALU results with queued multiply/divide results
//             onto the single write port and keeps a per-register busy
//             scoreboard for RAW (decode) and WAW (issue) interlocks.
//  Revision : 1.0  initial release
// ============================================================================
module reg_writeback #(
    parameter int unsigned QDEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic        issue_long,
    output logic        issue_ready,

    input  logic [4:0]  src_a_addr,
    input  logic [4:0]  src_b_addr,
    output logic        src_stall,

    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,

    input  logic        mdu_valid,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,

    output logic        rf_write_ena,
    output logic [4:0]  rf_address3,
    output logic [31:0] rf_write_data,

    output logic [31:0] busy_vec
);

    // ------------------------------------------------------------------------
    // Sizing constants
    // ------------------------------------------------------------------------
    localparam int unsigned      PTR_W    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned      CNT_W    = PTR_W + 1;
    localparam int unsigned      ENTRY_W  = 37;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    // Register 0 can never be busy, so its scoreboard bit is not stored.
    logic [31:1]        busy_q,          busy_d;
    logic [CNT_W-1:0]   long_cnt_q,      long_cnt_d;
    logic [CNT_W-1:0]   fifo_cnt_q,      fifo_cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q,        wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,        rd_ptr_d;
    logic               rf_write_ena_q,  rf_write_ena_d;
    logic [4:0]         rf_address3_q,   rf_address3_d;
    logic [31:0]        rf_write_data_q, rf_write_data_d;

    // MDU result storage, entries are {rd, data}
    logic [ENTRY_W-1:0] fifo_mem_q [QDEPTH];

    // ------------------------------------------------------------------------
    // Combinational wires
    // ------------------------------------------------------------------------
    logic [31:0]        busy_all;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               issue_accept;
    logic               long_inc;
    logic [ENTRY_W-1:0] head_entry;
    logic               sel_valid;
    logic [4:0]         sel_rd;
    logic [31:0]        sel_data;

    assign busy_all   = {busy_q, 1'b0};
    assign fifo_full  = (fifo_cnt_q == FULL_CNT);
    assign fifo_empty = (fifo_cnt_q == '0);
    assign head_entry = fifo_mem_q[rd_ptr_q];

    // Interlocks: WAW/long-op capacity for issue, RAW for decode, FIFO space for MDU
    always_comb begin
        issue_ready  = !(busy_all[issue_rd] && (issue_rd != 5'd0)) &&
                       !(issue_long && (long_cnt_q == FULL_CNT));
        issue_accept = issue_valid && issue_ready;
        long_inc     = issue_accept && issue_long;
        src_stall    = (busy_all[src_a_addr] && (src_a_addr != 5'd0)) ||
                       (busy_all[src_b_addr] && (src_b_addr != 5'd0));
        mdu_ready    = !fifo_full;
        push         = mdu_valid && !fifo_full;
    end

    // Write-port arbitration: ALU has absolute priority, FIFO head drains otherwise
    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = 5'd0;
        sel_data  = 32'd0;
        pop       = 1'b0;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_data;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_rd    = head_entry[36:32];
            sel_data  = head_entry[31:0];
            pop       = 1'b1;
        end
    end

    // Next-state of the registered write port; address/data hold when idle
    always_comb begin
        rf_write_ena_d  = sel_valid && (sel_rd != 5'd0);
        rf_address3_d   = rf_address3_q;
        rf_write_data_d = rf_write_data_q;
        if (rf_write_ena_d) begin
            rf_address3_d   = sel_rd;
            rf_write_data_d = sel_data;
        end
    end

    // Scoreboard update: retire on the write, mark on accepted issue (set wins)
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < 32; r++) begin
            if (rf_write_ena_q && (rf_address3_q == 5'(r))) begin
                busy_d[r] = 1'b0;
            end
            if (issue_accept && (issue_rd == 5'(r))) begin
                busy_d[r] = 1'b1;
            end
        end
    end

    // Outstanding long-op count and FIFO occupancy/pointer bookkeeping
    always_comb begin
        long_cnt_d = long_cnt_q;
        if (long_inc && !pop) begin
            long_cnt_d = long_cnt_q + CNT_ONE;
        end else if (!long_inc && pop && (long_cnt_q != '0)) begin
            // Saturate so a stray MDU result cannot wrap the counter
            long_cnt_d = long_cnt_q - CNT_ONE;
        end

        fifo_cnt_d = fifo_cnt_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_ONE;
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_ONE;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    end

    // Control state registers; reset drops any in-flight write immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q          <= '0;
            long_cnt_q      <= '0;
            fifo_cnt_q      <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            rf_write_ena_q  <= 1'b0;
            rf_address3_q   <= 5'd0;
            rf_write_data_q <= 32'd0;
        end else begin
            busy_q          <= busy_d;
            long_cnt_q      <= long_cnt_d;
            fifo_cnt_q      <= fifo_cnt_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            rf_write_ena_q  <= rf_write_ena_d;
            rf_address3_q   <= rf_address3_d;
            rf_write_data_q <= rf_write_data_d;
        end
    end

    // FIFO payload storage; contents are don't-care while the count is zero
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {mdu_rd, mdu_data};
        end
    end

    assign rf_write_ena  = rf_write_ena_q;
    assign rf_address3   = rf_address3_q;
    assign rf_write_data = rf_write_data_q;
    assign busy_vec      = busy_all;

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_writeback
//  Purpose  : Self-checking bench for reg_writeback. A behavioural model
//             predicts register-file writes into a scoreboard queue; a
//             monitor pops and compares as the DUT writes. Scenario tasks
//             add inline checks of interlocks and scoreboard contents.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_writeback;

    localparam int QDEPTH = 4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid, issue_long, issue_ready;
    logic [4:0]  issue_rd;
    logic [4:0]  src_a_addr, src_b_addr;
    logic        src_stall;
    logic        alu_valid, mdu_valid, mdu_ready;
    logic [4:0]  alu_rd, mdu_rd;
    logic [31:0] alu_data, mdu_data;
    logic        rf_write_ena;
    logic [4:0]  rf_address3;
    logic [31:0] rf_write_data;
    logic [31:0] busy_vec;

    int vectors     = 0;
    int miscompares = 0;

    reg_writeback #(.QDEPTH(QDEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_long    (issue_long),
        .issue_ready   (issue_ready),
        .src_a_addr    (src_a_addr),
        .src_b_addr    (src_b_addr),
        .src_stall     (src_stall),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .mdu_valid     (mdu_valid),
        .mdu_rd        (mdu_rd),
        .mdu_data      (mdu_data),
        .mdu_ready     (mdu_ready),
        .rf_write_ena  (rf_write_ena),
        .rf_address3   (rf_address3),
        .rf_write_data (rf_write_data),
        .busy_vec      (busy_vec)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------------
    wr_t         exp_q[$];
    wr_t         fifo_m[$];
    logic [31:0] busy_m;
    int          long_m;
    logic        wp_valid_m;
    logic [4:0]  wp_rd_m;
    logic        m_ready, m_full, m_pop, m_selv;
    wr_t         m_sel, mon_e;

    function automatic logic model_issue_ready(input logic [4:0] rd, input logic lng);
        return !(busy_m[rd] && (rd != 5'd0)) && !(lng && (long_m == QDEPTH));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            fifo_m.delete();
            busy_m     = 32'd0;
            long_m     = 0;
            wp_valid_m = 1'b0;
            wp_rd_m    = 5'd0;
        end else begin
            m_ready = model_issue_ready(issue_rd, issue_long);
            m_full  = (fifo_m.size() >= QDEPTH);
            m_pop   = 1'b0;
            m_selv  = 1'b0;
            m_sel   = '0;
            if (wp_valid_m) busy_m[wp_rd_m] = 1'b0;
            if (issue_valid && m_ready && issue_rd != 5'd0) busy_m[issue_rd] = 1'b1;
            if (alu_valid) begin
                m_sel  = '{rd: alu_rd, data: alu_data};
                m_selv = 1'b1;
            end else if (fifo_m.size() > 0) begin
                m_sel  = fifo_m.pop_front();
                m_selv = 1'b1;
                m_pop  = 1'b1;
            end
            if (mdu_valid && !m_full) fifo_m.push_back('{rd: mdu_rd, data: mdu_data});
            if (issue_valid && m_ready && issue_long) long_m++;
            if (m_pop && long_m > 0) long_m--;
            wp_valid_m = m_selv && (m_sel.rd != 5'd0);
            wp_rd_m    = m_sel.rd;
            if (wp_valid_m) exp_q.push_back(m_sel);
        end
    end

    // Write-port monitor: every cycle out of reset, compare against the model
    always @(negedge clk) begin
        if (!rst) begin
            vectors++;
            if (rf_write_ena !== wp_valid_m) begin
                miscompares++;
                $display("FAIL write_ena @%0t: got %b, expected %b", $time, rf_write_ena, wp_valid_m);
            end
            if (rf_write_ena === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL write_unexpected @%0t: got rd=%0d data=%h, expected no write",
                             $time, rf_address3, rf_write_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (rf_address3 !== mon_e.rd || rf_write_data !== mon_e.data) begin
                        miscompares++;
                        $display("FAIL write_data @%0t: got rd=%0d data=%h, expected rd=%0d data=%h",
                                 $time, rf_address3, rf_write_data, mon_e.rd, mon_e.data);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_rd = 5'd0; issue_long = 1'b0;
        src_a_addr  = 5'd0; src_b_addr = 5'd0;
        alu_valid   = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        mdu_valid   = 1'b0; mdu_rd = 5'd0; mdu_data = 32'd0;
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        src_a_addr = 5'd2;
        @(negedge clk);
        vectors++;
        if (rf_write_ena !== 1'b0 || rf_address3 !== 5'd0 || rf_write_data !== 32'd0) begin
            miscompares++;
            $display("FAIL por_rf: got ena=%b rd=%0d data=%h, expected 0/0/0", rf_write_ena, rf_address3, rf_write_data);
        end
        vectors++;
        if (busy_vec !== 32'd0 || issue_ready !== 1'b1 || mdu_ready !== 1'b1 || src_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL por_ctl: got busy=%h ir=%b mr=%b ss=%b, expected 0/1/1/0", busy_vec, issue_ready, mdu_ready, src_stall);
        end
        @(posedge clk); #1 rst = 1'b0;

        issue_valid = 1'b1; issue_rd = 5'd2; issue_long = 1'b1;
        step();
        issue_rd = 5'd8;
        step();
        issue_valid = 1'b0; issue_long = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0;
        mdu_valid = 1'b1; mdu_rd = 5'd2; mdu_data = 32'h2222_0002;
        step();
        alu_rd = 5'd20; alu_data = 32'h0000_1234;
        mdu_rd = 5'd8;  mdu_data = 32'h8888_0008;
        step();
        mdu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'h0;
        @(negedge clk);
        vectors++;
        if (busy_vec !== 32'h0000_0104 || src_stall !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_busy: got busy=%h ss=%b, expected 00000104/1", busy_vec, src_stall);
        end
        vectors++;
        if (rf_write_ena !== 1'b1 || rf_address3 !== 5'd20) begin
            miscompares++;
            $display("FAIL pre_reset_write: got ena=%b rd=%0d, expected 1/20", rf_write_ena, rf_address3);
        end
        #1 rst = 1'b1;
        alu_valid = 1'b0;
        #1;
        vectors++;
        if (rf_write_ena !== 1'b0 || rf_address3 !== 5'd0 || rf_write_data !== 32'd0 || busy_vec !== 32'd0) begin
            miscompares++;
            $display("FAIL async_reset_out: got ena=%b rd=%0d data=%h busy=%h, expected all 0",
                     rf_write_ena, rf_address3, rf_write_data, busy_vec);
        end
        vectors++;
        if (issue_ready !== 1'b1 || mdu_ready !== 1'b1 || src_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_ctl: got ir=%b mr=%b ss=%b, expected 1/1/0", issue_ready, mdu_ready, src_stall);
        end
        @(posedge clk); #1 rst = 1'b0;

        issue_valid = 1'b1; issue_rd = 5'd5; issue_long = 1'b0;
        step();
        issue_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy_vec !== 32'h0000_0020) begin
            miscompares++;
            $display("FAIL post_reset_issue: got busy=%h, expected 00000020", busy_vec);
        end
        step();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h5555_0005;
        step();
        alu_valid = 1'b0;
        step();
        @(negedge clk);
        vectors++;
        if (busy_vec !== 32'd0) begin
            miscompares++;
            $display("FAIL post_reset_retire: got busy=%h, expected 0", busy_vec);
        end
        idle_inputs();
    endtask

    task automatic test_alu_raw();
        step();
        issue_valid = 1'b1; issue_rd = 5'd8; issue_long = 1'b0;
        src_a_addr = 5'd8;
        step();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'hDEAD_BEEF;
        src_a_addr = 5'd0; src_b_addr = 5'd8;
        @(negedge clk);
        vectors++;
        if (src_stall !== 1'b1 || busy_vec !== 32'h0000_0100) begin
            miscompares++;
            $display("FAIL raw_cycle_n: got ss=%b busy=%h, expected 1/00000100", src_stall, busy_vec);
        end
        step();
        alu_valid = 1'b0;
        src_a_addr = 5'd8; src_b_addr = 5'd0;
        @(negedge clk);
        vectors++;
        if (rf_write_ena !== 1'b1 || rf_address3 !== 5'd8 || rf_write_data !== 32'hDEAD_BEEF || src_stall !== 1'b1) begin
            miscompares++;
            $display("FAIL raw_cycle_n1: got ena=%b rd=%0d data=%h ss=%b, expected 1/8/deadbeef/1",
                     rf_write_ena, rf_address3, rf_write_data, src_stall);
        end
        step();
        @(negedge clk);
        vectors++;
        if (src_stall !== 1'b0 || busy_vec !== 32'd0) begin
            miscompares++;
            $display("FAIL raw_cycle_n2: got ss=%b busy=%h, expected 0/0", src_stall, busy_vec);
        end
        idle_inputs();
    endtask

    task automatic test_arbitration();
        int order [5] = '{11, 12, 13, 9, 10};
        step();
        issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd9;  step();
        issue_rd = 5'd10; step();
        issue_long = 1'b0;
        issue_rd = 5'd11; step();
        issue_rd = 5'd12; step();
        issue_rd = 5'd13; step();
        issue_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            alu_valid = (c <= 3); alu_rd = 5'(10 + c); alu_data = 32'hA1A0_0000 + 32'(c);
            mdu_valid = (c <= 2); mdu_rd = 5'(8 + c);  mdu_data = 32'hD0D0_0000 + 32'(c);
            @(negedge clk);
            if (c >= 2) begin
                vectors++;
                if (rf_write_ena !== 1'b1 || rf_address3 !== 5'(order[c-2])) begin
                    miscompares++;
                    $display("FAIL arb_order[%0d]: got ena=%b rd=%0d, expected 1/%0d", c - 2, rf_write_ena, rf_address3, order[c-2]);
                end
            end
            step();
        end
        idle_inputs();
        @(negedge clk);
        vectors++;
        if (busy_vec !== 32'd0) begin
            miscompares++;
            $display("FAIL arb_busy_clear: got busy=%h, expected 0", busy_vec);
        end
    endtask

    task automatic test_full_backpressure();
        step();
        issue_valid = 1'b1; issue_long = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            issue_rd = 5'(i);
            @(negedge clk);
            vectors++;
            if (issue_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL long_issue[%0d]: got ready=%b, expected 1", i, issue_ready);
            end
            step();
        end
        issue_rd = 5'd14;
        @(negedge clk);
        vectors++;
        if (issue_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fifth_long: got ready=%b, expected 0", issue_ready);
        end
        step();
        issue_rd = 5'd6; issue_long = 1'b0;
        @(negedge clk);
        vectors++;
        if (issue_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL short_while_full: got ready=%b, expected 1", issue_ready);
        end
        step();
        issue_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy_vec !== 32'h0000_005E) begin
            miscompares++;
            $display("FAIL full_busy: got busy=%h, expected 0000005e", busy_vec);
        end
        step();
        for (int i = 1; i <= 4; i++) begin
            mdu_valid = 1'b1; mdu_rd = 5'(i); mdu_data = 32'hC0DE_0000 + 32'(i);
            alu_valid = 1'b1; alu_rd = (i == 1) ? 5'd6 : 5'd0; alu_data = 32'h6666_6666;
            @(negedge clk);
            vectors++;
            if (mdu_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL fill_ready[%0d]: got %b, expected 1", i, mdu_ready);
            end
            step();
        end
        mdu_valid = 1'b0; alu_rd = 5'd0;
        issue_valid = 1'b1; issue_rd = 5'd15; issue_long = 1'b1;
        @(negedge clk);
        vectors++;
        if (mdu_ready !== 1'b0 || issue_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_state: got mr=%b ir=%b, expected 0/0", mdu_ready, issue_ready);
        end
        step();
        issue_valid = 1'b0; alu_valid = 1'b0;
        mdu_valid = 1'b1; mdu_rd = 5'd15; mdu_data = 32'hF00D_000F;
        @(negedge clk);
        vectors++;
        if (mdu_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL pop_while_full: got mr=%b, expected 0", mdu_ready);
        end
        step();
        mdu_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd15; issue_long = 1'b1;
        @(negedge clk);
        vectors++;
        if (mdu_ready !== 1'b1 || issue_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL after_pop: got mr=%b ir=%b, expected 1/1", mdu_ready, issue_ready);
        end
        step();
        issue_valid = 1'b0;
        mdu_valid = 1'b1; mdu_rd = 5'd15; mdu_data = 32'hF00D_000F;
        @(negedge clk);
        vectors++;
        if (mdu_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL push_pop_ready: got mr=%b, expected 1", mdu_ready);
        end
        step();
        idle_inputs();
        repeat (8) step();
        @(negedge clk);
        vectors++;
        if (busy_vec !== 32'd0) begin
            miscompares++;
            $display("FAIL full_drain_busy: got busy=%h, expected 0", busy_vec);
        end
    endtask

    task automatic test_waw_zero();
        step();
        issue_valid = 1'b1; issue_rd = 5'd7; issue_long = 1'b0;
        @(negedge clk);
        vectors++;
        if (issue_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL waw_first: got ready=%b, expected 1", issue_ready);
        end
        step();
        @(negedge clk);
        vectors++;
        if (issue_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL waw_block: got ready=%b, expected 0", issue_ready);
        end
        step();
        issue_rd = 5'd0;
        @(negedge clk);
        vectors++;
        if (issue_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_issue_ready: got ready=%b, expected 1", issue_ready);
        end
        step();
        issue_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy_vec !== 32'h0000_0080) begin
            miscompares++;
            $display("FAIL zero_issue_busy: got busy=%h, expected 00000080", busy_vec);
        end
        step();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hBAD0_0000;
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (rf_write_ena !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_alu_write: got ena=%b, expected 0", rf_write_ena);
        end
        step();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h7777_0007;
        step();
        alu_valid = 1'b0;
        step();
        @(negedge clk);
        vectors++;
        if (busy_vec !== 32'd0) begin
            miscompares++;
            $display("FAIL waw_retire: got busy=%h, expected 0", busy_vec);
        end
        idle_inputs();
    endtask

    task automatic test_pointer_wrap();
        int   ni  = 0;
        int   np  = 0;
        int   cyc = 0;
        logic exp_rdy;
        step();
        while ((ni < 10 || np < 10) && cyc < 300) begin
            issue_valid = (ni < 10); issue_rd = 5'(16 + ni); issue_long = 1'b1;
            exp_rdy     = model_issue_ready(issue_rd, 1'b1);
            mdu_valid   = (np < ni) && (fifo_m.size() < QDEPTH);
            mdu_rd      = 5'(16 + np); mdu_data = 32'h5A00_0000 + 32'(np);
            alu_valid   = ((cyc % 3) != 2); alu_rd = 5'd30; alu_data = 32'hA100_0000 + 32'(cyc);
            @(negedge clk);
            if (ni < 10) begin
                vectors++;
                if (issue_ready !== exp_rdy) begin
                    miscompares++;
                    $display("FAIL wrap_issue_ready cyc%0d: got %b, expected %b", cyc, issue_ready, exp_rdy);
                end
            end
            vectors++;
            if (mdu_ready !== (fifo_m.size() < QDEPTH)) begin
                miscompares++;
                $display("FAIL wrap_mdu_ready cyc%0d: got %b, expected %b", cyc, mdu_ready, (fifo_m.size() < QDEPTH));
            end
            if (issue_valid && exp_rdy) ni++;
            if (mdu_valid) np++;
            step();
            cyc++;
        end
        if (cyc >= 300) begin
            vectors++;
            miscompares++;
            $display("FAIL wrap_timeout: got issued=%0d pushed=%0d, expected 10/10", ni, np);
        end
        idle_inputs();
        repeat (12) step();
        @(negedge clk);
        vectors++;
        if (busy_vec !== 32'd0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL wrap_drain: got busy=%h pending=%0d, expected 0/0", busy_vec, exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_alu_raw();
        test_arbitration();
        test_full_backpressure();
        test_waw_zero();
        test_pointer_wrap();
        step();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL final_scoreboard: got %0d pending writes, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
